// File: rtl/field_builder.sv
// Multi-cycle snake field rasteriser: clear, draw segments, count empties, optionally place an apple.
// Optional perimeter walls are enabled by defining FIELD_WALLS_EN.
module field_builder #(
  parameter int SIZE_X  = 10,
  parameter int SIZE_Y  = 10,
  parameter int COORD_W = 8,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         place_apple,
  input  logic [LEN_W-1:0]             length,
  input  logic [2*COORD_W*MAX_LEN-1:0] snake_xy,
  input  logic [LEN_W-1:0]             rand_idx,
  output logic                         busy,
  output logic                         done,
  output logic [2*SIZE_X*SIZE_Y-1:0]   field,
  output logic [LEN_W-1:0]             empty_cells,
  output logic                         apple_ok,
  output logic [COORD_W-1:0]           apple_x,
  output logic [COORD_W-1:0]           apple_y,
  output logic                         collide,
  output logic                         oob
);

  localparam int CELLS = SIZE_X * SIZE_Y;
  localparam int CW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int SW    = $clog2(MAX_LEN + 1);
`ifdef FIELD_WALLS_EN
  localparam bit WALLS_ON = 1'b1;
  localparam int WALLS    = (SIZE_X < 2 || SIZE_Y < 2) ? CELLS : 2*SIZE_X + 2*SIZE_Y - 4;
`else
  localparam bit WALLS_ON = 1'b0;
  localparam int WALLS    = 0;
`endif
  localparam logic [LEN_W-1:0] EMPTY0 = LEN_W'(CELLS - WALLS);

  typedef enum logic [2:0] {IDLE, CLEAR, DRAW, COUNT, MOD, SCAN, DONE} state_t;

  state_t             state;
  logic [SW-1:0]      len_q, seg;
  logic               pa_q, head_v;
  logic [LEN_W-1:0]   target, scan_k;
  logic [CW-1:0]      head_idx, scan_c;
  logic [COORD_W-1:0] scan_x, scan_y;

  function automatic logic is_wall(input int c);
    return WALLS_ON && ((c % SIZE_X == 0) || (c % SIZE_X == SIZE_X - 1) ||
                        (c / SIZE_X == 0) || (c / SIZE_X == SIZE_Y - 1));
  endfunction

  // Snake cells always vanish; apples survive unless a new one is due; walls are re-asserted.
  function automatic logic [2*CELLS-1:0] cleared(input logic [2*CELLS-1:0] f, input logic pa);
    logic [2*CELLS-1:0] r;
    r = '0;
    for (int c = 0; c < CELLS; c++) begin
      if (is_wall(c) || f[2*c +: 2] == 2'b11) r[2*c +: 2] = 2'b11;
      else if (f[2*c +: 2] == 2'b10 && !pa)   r[2*c +: 2] = 2'b10;
    end
    return r;
  endfunction

  logic [LEN_W-1:0]   n_empty;
  logic [SW-1:0]      len_c;
  logic [COORD_W-1:0] seg_x, seg_y;
  logic               in_rng;
  logic [CW-1:0]      seg_idx;
  logic [1:0]         seg_cell, scan_cell;

  always_comb begin
    n_empty = '0;
    for (int c = 0; c < CELLS; c++)
      if (field[2*c +: 2] == 2'b00) n_empty = n_empty + LEN_W'(1);
  end

  assign len_c     = (length > LEN_W'(MAX_LEN)) ? SW'(MAX_LEN) : length[SW-1:0];
  assign seg_x     = snake_xy[2*COORD_W*seg +: COORD_W];
  assign seg_y     = snake_xy[2*COORD_W*seg + COORD_W +: COORD_W];
  assign in_rng    = (seg_x < COORD_W'(SIZE_X)) && (seg_y < COORD_W'(SIZE_Y));
  assign seg_idx   = CW'(seg_y) * CW'(SIZE_X) + CW'(seg_x);
  assign seg_cell  = field[2*seg_idx +: 2];
  assign scan_cell = field[2*scan_c +: 2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      field       <= cleared('0, 1'b1);
      empty_cells <= EMPTY0;
      busy        <= 1'b0;
      done        <= 1'b0;
      apple_ok    <= 1'b0;
      apple_x     <= '0;
      apple_y     <= '0;
      collide     <= 1'b0;
      oob         <= 1'b0;
      len_q       <= '0;
      seg         <= '0;
      pa_q        <= 1'b0;
      head_v      <= 1'b0;
      target      <= '0;
      scan_k      <= '0;
      head_idx    <= '0;
      scan_c      <= '0;
      scan_x      <= '0;
      scan_y      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len_q    <= len_c;
          pa_q     <= place_apple;
          target   <= rand_idx;
          busy     <= 1'b1;
          collide  <= 1'b0;
          oob      <= 1'b0;
          apple_ok <= 1'b0;
          seg      <= '0;
          head_v   <= 1'b0;
          state    <= CLEAR;
        end
        CLEAR: begin
          field <= cleared(field, pa_q);
          state <= (len_q == '0) ? COUNT : DRAW;
        end
        DRAW: begin
          if (in_rng) begin
            field[2*seg_idx +: 2] <= 2'b01;
            if (seg == '0) begin
              head_idx <= seg_idx;
              head_v   <= 1'b1;
              if (seg_cell == 2'b11) collide <= 1'b1;
            end else if (head_v && seg_idx == head_idx && seg_cell == 2'b01) begin
              collide <= 1'b1;
            end
          end else begin
            oob <= 1'b1;
          end
          seg <= seg + SW'(1);
          if (seg == len_q - SW'(1)) state <= COUNT;
        end
        COUNT: begin
          empty_cells <= n_empty;
          scan_c      <= '0;
          scan_x      <= '0;
          scan_y      <= '0;
          scan_k      <= '0;
          state       <= (!pa_q || n_empty == '0) ? DONE : MOD;
        end
        // Serial modulo keeps the datapath to one subtractor.
        MOD: begin
          if (target >= empty_cells) target <= target - empty_cells;
          else                       state  <= SCAN;
        end
        SCAN: begin
          if (scan_cell == 2'b00) begin
            if (scan_k == target) begin
              field[2*scan_c +: 2] <= 2'b10;
              apple_x     <= scan_x;
              apple_y     <= scan_y;
              apple_ok    <= 1'b1;
              empty_cells <= empty_cells - LEN_W'(1);
              state       <= DONE;
            end else begin
              scan_k <= scan_k + LEN_W'(1);
            end
          end
          scan_c <= scan_c + CW'(1);
          if (scan_x == COORD_W'(SIZE_X - 1)) begin
            scan_x <= '0;
            scan_y <= scan_y + COORD_W'(1);
          end else begin
            scan_x <= scan_x + COORD_W'(1);
          end
          if (scan_c == CW'(CELLS - 1)) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_field_builder.sv
// Bench for field_builder: 10x10 and 2x2 instances checked against a cell-array model of a frame.
module tb_field_builder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, start2, pa;
  logic [15:0]  length, rand_idx;
  logic [1023:0] snake;
  logic [63:0]  snake2;

  logic         busy1, done1, aok1, col1, oob1;
  logic [199:0] field1;
  logic [15:0]  empty1;
  logic [7:0]   ax1, ay1;
  logic         busy2, done2, aok2, col2, oob2;
  logic [7:0]   field2;
  logic [15:0]  empty2;
  logic [7:0]   ax2, ay2;

  field_builder dut (
    .clk(clk), .rst(rst), .start(start), .place_apple(pa), .length(length),
    .snake_xy(snake), .rand_idx(rand_idx), .busy(busy1), .done(done1),
    .field(field1), .empty_cells(empty1), .apple_ok(aok1), .apple_x(ax1),
    .apple_y(ay1), .collide(col1), .oob(oob1));

  field_builder #(.SIZE_X(2), .SIZE_Y(2), .MAX_LEN(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .place_apple(pa), .length(length),
    .snake_xy(snake2), .rand_idx(rand_idx), .busy(busy2), .done(done2),
    .field(field2), .empty_cells(empty2), .apple_ok(aok2), .apple_x(ax2),
    .apple_y(ay2), .collide(col2), .oob(oob2));

  int sel = 0;
  logic         m_busy, m_done, m_aok, m_col, m_oob;
  logic [199:0] m_field;
  logic [15:0]  m_empty;
  logic [7:0]   m_ax, m_ay;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_done  = sel ? done2  : done1;
  assign m_aok   = sel ? aok2   : aok1;
  assign m_col   = sel ? col2   : col1;
  assign m_oob   = sel ? oob2   : oob1;
  assign m_field = sel ? {192'b0, field2} : field1;
  assign m_empty = sel ? empty2 : empty1;
  assign m_ax    = sel ? ax2    : ax1;
  assign m_ay    = sel ? ay2    : ay1;

  int total = 0, bad = 0;
  int frames = 0, done_at = -1;
  event kick;

  task automatic check(input string nm, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model state: per-instance cell contents and last apple position.
  int mf [2][100];
  int axm [2], aym [2];
  int sgx [64], sgy [64];
  logic [199:0] e_field;
  int e_empty, e_aok, e_ax, e_ay, e_col, e_oob, e_lat;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 100; c++) mf[d][c] = 0;
      axm[d] = 0; aym[d] = 0;
    end
  endtask

  task automatic set_seg(input int i, input int x, input int y);
    sgx[i] = x; sgy[i] = y;
    snake[16*i +: 8] = x[7:0]; snake[16*i+8 +: 8] = y[7:0];
    if (i < 4) begin snake2[16*i +: 8] = x[7:0]; snake2[16*i+8 +: 8] = y[7:0]; end
  endtask

  // A frame in plain terms: wipe snake (and old apple if a new one is due), paint the
  // snake, then the apple goes to the (rand mod empties)-th empty cell in raster order.
  task automatic model_frame(input int d, input int L, input bit p, input int r);
    int sx, n, head, e, t, k, pick;
    sx = d ? 2 : 10; n = d ? 4 : 100;
    e_col = 0; e_oob = 0; e_aok = 0; head = -1;
    for (int c = 0; c < n; c++)
      if (mf[d][c] == 1 || (mf[d][c] == 2 && p)) mf[d][c] = 0;
    for (int i = 0; i < L; i++) begin
      if (sgx[i] >= sx || sgy[i] >= n / sx) e_oob = 1;
      else begin
        int c;
        c = sgy[i] * sx + sgx[i];
        if (i == 0) begin head = c; if (mf[d][c] == 3) e_col = 1; end
        else if (c == head && mf[d][c] == 1) e_col = 1;
        mf[d][c] = 1;
      end
    end
    e = 0;
    for (int c = 0; c < n; c++) if (mf[d][c] == 0) e++;
    e_lat = L + 3;
    if (p && e > 0) begin
      t = r % e; k = 0; pick = -1;
      for (int c = 0; c < n; c++)
        if (mf[d][c] == 0 && pick < 0) begin
          if (k == t) pick = c;
          k++;
        end
      mf[d][pick] = 2;
      axm[d] = pick % sx; aym[d] = pick / sx;
      e_aok = 1;
      e_lat = L + 5 + r / e + pick;
      e--;
    end
    e_empty = e; e_ax = axm[d]; e_ay = aym[d];
    e_field = '0;
    for (int c = 0; c < n; c++) e_field[2*c +: 2] = mf[d][c][1:0];
  endtask

  // Compare process: busy/done every cycle of a frame, full output set at done.
  initial begin
    forever begin
      @(kick);
      done_at = -1;
      for (int c = 0; c <= e_lat; c++) begin
        @(negedge clk);
        check("busy", m_busy, c < e_lat);
        check("done", m_done, c == e_lat);
        if (m_done && done_at < 0) done_at = c;
      end
      check("field", m_field, e_field);
      check("empty_cells", m_empty, e_empty);
      check("apple_ok", m_aok, e_aok);
      check("apple_x", m_ax, e_ax);
      check("apple_y", m_ay, e_ay);
      check("collide", m_col, e_col);
      check("oob", m_oob, e_oob);
      frames++;
    end
  end

  task automatic run(input int d, input int len, input bit p, input int r);
    int tgt;
    sel = d;
    model_frame(d, (len > (d ? 4 : 64)) ? (d ? 4 : 64) : len, p, r);
    @(negedge clk);
    length = len[15:0]; pa = p; rand_idx = r[15:0];
    if (d == 1) start2 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; start2 = 1'b0;
    tgt = frames + 1;
    -> kick;
    for (int w = 0; w < 5000 && frames < tgt; w++) @(posedge clk);
    check("frame_timeout", frames >= tgt, 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; pa = 1'b0;
    length = '0; rand_idx = '0; snake = '0; snake2 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_field", field1, 200'd0);
    check("rst_empty", empty1, 100);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_flags", {aok1, col1, oob1, ax1, ay1}, 0);
    check("rst_empty2", empty2, 4);

    set_seg(0, 2, 1); set_seg(1, 1, 1); set_seg(2, 0, 1);
    run(0, 3, 0, 0);
    check("lit_latency", done_at, 6);
    check("lit_empty97", empty1, 97);
    check("lit_cells10_12", field1[25:20], 6'b010101);

    run(0, 3, 1, 0);
    check("lit_apple0", {field1[1:0], ax1, ay1}, {2'b10, 8'd0, 8'd0});
    check("lit_empty96", empty1, 96);

    run(0, 3, 1, 250);
    check("lit_apple59", {ax1, ay1, field1[119:118]}, {8'd9, 8'd5, 2'b10});

    set_seg(0, 1, 1); set_seg(1, 2, 1); set_seg(2, 1, 1);
    run(0, 3, 0, 0);
    check("lit_collide", col1, 1);

    set_seg(0, 12, 0); set_seg(1, 3, 3);
    run(0, 2, 0, 0);
    check("lit_oob", {oob1, col1}, 2'b10);

    for (int i = 0; i < 64; i++) set_seg(i, i % 10, i / 10);
    run(0, 100, 1, 7);
    check("lit_clamp_apple", {ax1, ay1, empty1}, {8'd1, 8'd7, 16'd35});

    run(0, 0, 1, 3);
    check("lit_len0", {ax1, ay1, empty1}, {8'd3, 8'd0, 16'd99});

    for (int i = 0; i < 5; i++) set_seg(i, 5 + i, 5);
    @(negedge clk);
    length = 16'd5; pa = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 check("mid_busy", busy1, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_busy", busy1, 0);
    check("abort_field", field1, 200'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done1) seen++;
      @(negedge clk);
    end
    check("abort_no_done", seen, 0);

    run(0, 5, 1, 120);
    check("lit_after_abort", {ax1, ay1, aok1}, {8'd5, 8'd2, 1'b1});

    set_seg(0, 0, 0); set_seg(1, 1, 0); set_seg(2, 0, 1); set_seg(3, 1, 1);
    run(1, 4, 1, 9);
    check("lit_full_board", {empty2, aok2}, {16'd0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
